// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
//   - Access size codes (byte/half/word) as seen on d_size/mem_size.
//   - Arbiter FSM state codes and transaction owner codes.
//   - Latched memory request record and a saturating 8-bit increment.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        rdun;
  } mem_req_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every requester and memory-side signal of the arbiter.
//   fetch:  i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   data:   d_req, d_addr, d_wdata, d_we, d_size, d_rdun -> d_gnt, d_rvalid, d_rdata
//   memory: mem_addr, mem_wdata, mem_we, mem_size, mem_rdun <- mem_rdata
// slave  : the arbiter's view.
// master : the requesters' and memory model's view.
interface mem_port_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_rdun;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_rdun;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_we, d_size, d_rdun, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wdata, mem_we, mem_size, mem_rdun
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_we, d_size, d_rdun, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_size, mem_rdun
  );

endinterface

// File: rtl/mem_port_arbiter_arb_prio_sel.sv
// Combinational winner pick between fetch and data.
//   en      : arbiter able to accept a request this cycle
//   i_req   : fetch request
//   d_req   : data request
//   promote : fetch has waited long enough to beat data
//   i_gnt   : fetch wins
//   d_gnt   : data wins
// Data has priority unless fetch has been promoted.
module mem_port_arbiter_arb_prio_sel (
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  input  logic promote,
  output logic i_gnt,
  output logic d_gnt
);

  always_comb begin
    i_gnt = en && i_req && (!d_req || promote);
    d_gnt = en && d_req && !(i_req && promote);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction outstanding at a time. A grant is possible in IDLE or in
// the final BUSY cycle (the rvalid cycle), so back-to-back transactions
// issue every MEM_LAT cycles.
// Parameters:
//   MEM_LAT  (1..15)  cycles from mem_* presented to mem_rdata valid
//   MAX_WAIT (1..255) consecutive denied fetch cycles before fetch is promoted
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (fetch, data and memory signals)
// Optional feature, macro ARB_PERF_CNT_EN: adds perf_i_grants, perf_d_grants,
// perf_i_stall (32-bit, wrapping) outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_i_grants,
  output logic [31:0]           perf_d_grants,
  output logic [31:0]           perf_i_stall
`endif
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT);
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  mem_req_t   req_q, req_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_we_q, mem_we_d;

  logic last_cycle, can_grant, promote;
  logic i_gnt, d_gnt, i_rv, d_rv;

  // lat_cnt counts BUSY cycles starting at 1 in the cycle after the grant.
  assign last_cycle = (state_q == ARB_BUSY) && (lat_cnt_q == LAT_LAST);
  assign can_grant  = (state_q == ARB_IDLE) || last_cycle;
  assign promote    = (wait_cnt_q >= WAIT_LIM);

  mem_port_arbiter_arb_prio_sel u_arb_prio_sel (
    .en      (can_grant),
    .i_req   (bus.i_req),
    .d_req   (bus.d_req),
    .promote (promote),
    .i_gnt   (i_gnt),
    .d_gnt   (d_gnt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (i_gnt || d_gnt) state_d = ARB_BUSY;
    else if (can_grant) state_d = ARB_IDLE;
  end

  // Outputs: grants and completion are combinational from current state
  always_comb begin
    i_rv         = last_cycle && (owner_q == ARB_OWN_I);
    d_rv         = last_cycle && (owner_q == ARB_OWN_D);
    bus.i_gnt    = i_gnt;
    bus.d_gnt    = d_gnt;
    bus.i_rvalid = i_rv;
    bus.d_rvalid = d_rv;
    bus.i_rdata  = i_rv ? bus.mem_rdata : 32'd0;
    bus.d_rdata  = (d_rv && !req_q.we) ? bus.mem_rdata : 32'd0;
  end

  // Transaction capture, latency and fetch-wait bookkeeping
  always_comb begin
    owner_d   = owner_q;
    req_d     = req_q;
    lat_cnt_d = lat_cnt_q;
    mem_we_d  = 1'b0;
    if (state_q == ARB_BUSY && !last_cycle) lat_cnt_d = lat_cnt_q + 4'd1;
    if (d_gnt) begin
      owner_d   = ARB_OWN_D;
      req_d     = '{addr: bus.d_addr, wdata: bus.d_wdata, we: bus.d_we,
                    size: bus.d_size, rdun: bus.d_rdun};
      mem_we_d  = bus.d_we;
      lat_cnt_d = 4'd1;
    end else if (i_gnt) begin
      owner_d   = ARB_OWN_I;
      req_d     = '{addr: bus.i_addr, wdata: 32'd0, we: 1'b0,
                    size: SIZE_WORD, rdun: 1'b0};
      lat_cnt_d = 4'd1;
    end
    // Any cycle fetch asks and is refused counts, including while BUSY.
    wait_cnt_d = (bus.i_req && !i_gnt) ? sat_inc8(wait_cnt_q) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= ARB_OWN_I;
      req_q      <= '0;
      lat_cnt_q  <= 4'd0;
      wait_cnt_q <= 8'd0;
      mem_we_q   <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      req_q      <= req_d;
      lat_cnt_q  <= lat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_we_q   <= mem_we_d;
    end
  end

  // mem_we is high only in the first cycle after a store grant.
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.mem_size  = req_q.size;
  assign bus.mem_rdun  = req_q.rdun;
  assign bus.mem_we    = mem_we_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_grants_q, perf_i_grants_d;
  logic [31:0] perf_d_grants_q, perf_d_grants_d;
  logic [31:0] perf_i_stall_q,  perf_i_stall_d;

  always_comb begin
    perf_i_grants_d = perf_i_grants_q + {31'd0, i_gnt};
    perf_d_grants_d = perf_d_grants_q + {31'd0, d_gnt};
    perf_i_stall_d  = perf_i_stall_q  + {31'd0, (bus.i_req && !i_gnt)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants_q <= 32'd0;
      perf_d_grants_q <= 32'd0;
      perf_i_stall_q  <= 32'd0;
    end else begin
      perf_i_grants_q <= perf_i_grants_d;
      perf_d_grants_q <= perf_d_grants_d;
      perf_i_stall_q  <= perf_i_stall_d;
    end
  end

  assign perf_i_grants = perf_i_grants_q;
  assign perf_d_grants = perf_d_grants_q;
  assign perf_i_stall  = perf_i_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Two instances (MEM_LAT=1 and MEM_LAT=3, both
// MAX_WAIT=4) share the same request stimulus; each is compared every cycle
// against a transaction-level reference model. With ARB_PERF_CNT_EN defined
// the performance counters are also compared.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned LAT0     = 1;
  localparam int unsigned LAT1     = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_rdun;

  mem_port_arbiter_if bus1();
  mem_port_arbiter_if bus3();

  // Stateless memory: each address reads back a fixed scramble of itself.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign bus1.i_req   = i_req;   assign bus3.i_req   = i_req;
  assign bus1.i_addr  = i_addr;  assign bus3.i_addr  = i_addr;
  assign bus1.d_req   = d_req;   assign bus3.d_req   = d_req;
  assign bus1.d_addr  = d_addr;  assign bus3.d_addr  = d_addr;
  assign bus1.d_wdata = d_wdata; assign bus3.d_wdata = d_wdata;
  assign bus1.d_we    = d_we;    assign bus3.d_we    = d_we;
  assign bus1.d_size  = d_size;  assign bus3.d_size  = d_size;
  assign bus1.d_rdun  = d_rdun;  assign bus3.d_rdun  = d_rdun;
  assign bus1.mem_rdata = mem_word(bus1.mem_addr);
  assign bus3.mem_rdata = mem_word(bus3.mem_addr);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] p1_ig, p1_dg, p1_st, p3_ig, p3_dg, p3_st;
`endif

  mem_port_arbiter #(.MEM_LAT(LAT0), .MAX_WAIT(MAX_WAIT)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_i_grants (p1_ig),
    .perf_d_grants (p1_dg),
    .perf_i_stall  (p1_st)
`endif
  );

  mem_port_arbiter #(.MEM_LAT(LAT1), .MAX_WAIT(MAX_WAIT)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_i_grants (p3_ig),
    .perf_d_grants (p3_dg),
    .perf_i_stall  (p3_st)
`endif
  );

  // Reference model: one outstanding transaction per instance, described by
  // the cycle it was granted and the cycle its result is due.
  longint      cyc;
  bit          m_busy  [2];
  longint      m_gcyc  [2];
  longint      m_done  [2];
  bit          m_own_d [2];
  bit          m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [1:0]  m_size  [2];
  bit          m_rdun  [2];
  int          m_wait  [2];
  int          m_ig    [2];
  int          m_dg    [2];
  int          m_st    [2];
  bit          obs_ign [2];
  bit          obs_dgn [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_gcyc[k] = 0; m_done[k] = 0; m_own_d[k] = 0; m_we[k] = 0;
      m_addr[k] = '0; m_wdata[k] = '0; m_size[k] = '0; m_rdun[k] = 0;
      m_wait[k] = 0; m_ig[k] = 0; m_dg[k] = 0; m_st[k] = 0;
    end
  endtask

  task automatic model_check(input int k, input int lat,
                             input logic ig, input logic dg, input logic irv, input logic drv,
                             input logic [31:0] ird, input logic [31:0] drd,
                             input logic [31:0] maddr, input logic [31:0] mwd,
                             input logic mwe, input logic [1:0] msz, input logic mrd);
    bit fin, freep, wi, wd;
    string p;
    p     = $sformatf("L%0d", lat);
    fin   = m_busy[k] && (cyc == m_done[k]);
    freep = !m_busy[k] || fin;
    wi    = freep && i_req && (!d_req || m_wait[k] >= int'(MAX_WAIT));
    wd    = freep && d_req && !wi;
    check_val({p, " i_gnt"},    ig,  wi);
    check_val({p, " d_gnt"},    dg,  wd);
    check_val({p, " i_rvalid"}, irv, fin && !m_own_d[k]);
    check_val({p, " d_rvalid"}, drv, fin && m_own_d[k]);
    check_val({p, " mem_we"},   mwe, m_busy[k] && (cyc == m_gcyc[k] + 1) && m_we[k]);
    if (fin && !m_own_d[k]) check_val({p, " i_rdata"}, ird, mem_word(m_addr[k]));
    if (fin && m_own_d[k])  check_val({p, " d_rdata"}, drd, m_we[k] ? 32'd0 : mem_word(m_addr[k]));
    if (m_busy[k]) begin
      check_val({p, " mem_addr"}, maddr, m_addr[k]);
      check_val({p, " mem_size"}, msz,   m_size[k]);
      check_val({p, " mem_rdun"}, mrd,   m_rdun[k]);
      if (m_own_d[k]) check_val({p, " mem_wdata"}, mwd, m_wdata[k]);
    end
    obs_ign[k] = ig;
    obs_dgn[k] = dg;
    if (i_req && !wi) begin
      m_wait[k] = (m_wait[k] < 255) ? m_wait[k] + 1 : 255;
      m_st[k]++;
    end else begin
      m_wait[k] = 0;
    end
    if (wi || wd) begin
      m_busy[k]  = 1;
      m_gcyc[k]  = cyc;
      m_done[k]  = cyc + lat;
      m_own_d[k] = wd;
      if (wd) begin
        m_we[k] = d_we; m_addr[k] = d_addr; m_wdata[k] = d_wdata;
        m_size[k] = d_size; m_rdun[k] = d_rdun; m_dg[k]++;
      end else begin
        m_we[k] = 0; m_addr[k] = i_addr; m_wdata[k] = '0;
        m_size[k] = SIZE_WORD; m_rdun[k] = 0; m_ig[k]++;
      end
    end else if (fin) begin
      m_busy[k] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check(0, LAT0, bus1.i_gnt, bus1.d_gnt, bus1.i_rvalid, bus1.d_rvalid,
                bus1.i_rdata, bus1.d_rdata, bus1.mem_addr, bus1.mem_wdata,
                bus1.mem_we, bus1.mem_size, bus1.mem_rdun);
    model_check(1, LAT1, bus3.i_gnt, bus3.d_gnt, bus3.i_rvalid, bus3.d_rvalid,
                bus3.i_rdata, bus3.d_rdata, bus3.mem_addr, bus3.mem_wdata,
                bus3.mem_we, bus3.mem_size, bus3.mem_rdun);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle();
    i_req = 0; i_addr = '0; d_req = 0; d_addr = '0; d_wdata = '0;
    d_we = 0; d_size = SIZE_WORD; d_rdun = 0;
  endtask

  task automatic chk_quiet(input string p, input logic ig, input logic dg, input logic irv,
                           input logic drv, input logic mwe, input logic [31:0] maddr,
                           input logic [31:0] mwd, input logic [31:0] ird, input logic [31:0] drd);
    check_val({p, " rst i_gnt"},     ig,    0);
    check_val({p, " rst d_gnt"},     dg,    0);
    check_val({p, " rst i_rvalid"},  irv,   0);
    check_val({p, " rst d_rvalid"},  drv,   0);
    check_val({p, " rst mem_we"},    mwe,   0);
    check_val({p, " rst mem_addr"},  maddr, 0);
    check_val({p, " rst mem_wdata"}, mwd,   0);
    check_val({p, " rst i_rdata"},   ird,   0);
    check_val({p, " rst d_rdata"},   drd,   0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("L1", bus1.i_gnt, bus1.d_gnt, bus1.i_rvalid, bus1.d_rvalid, bus1.mem_we,
              bus1.mem_addr, bus1.mem_wdata, bus1.i_rdata, bus1.d_rdata);
    chk_quiet("L3", bus3.i_gnt, bus3.d_gnt, bus3.i_rvalid, bus3.d_rvalid, bus3.mem_we,
              bus3.mem_addr, bus3.mem_wdata, bus3.i_rdata, bus3.d_rdata);
`ifdef ARB_PERF_CNT_EN
    check_val("L1 rst perf_i_grants", p1_ig, 0);
    check_val("L3 rst perf_i_stall",  p3_st, 0);
`endif
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  dcnt;
    bit  seen;
    cyc   = 0;
    rst_n = 0;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Lone fetch
    i_req = 1; i_addr = 32'h0100_0000;
    step();
    idle();
    repeat (4) step();

    // Both requesters every cycle: data wins until fetch is promoted
    do_reset();
    dcnt = 0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      i_req = 1; d_req = 1; d_we = 0; d_size = SIZE_WORD;
      i_addr = $urandom; d_addr = $urandom;
      step();
      if (!seen) begin
        if (obs_dgn[0]) dcnt++;
        if (obs_ign[0]) seen = 1;
      end
    end
    check_val("L1 data_wins_before_promote", dcnt, 4);
    check_val("L1 fetch_promoted", {31'd0, seen}, 1);
    idle();
    repeat (4) step();

    // Byte store
    d_req = 1; d_we = 1; d_size = SIZE_BYTE; d_addr = 32'h0100_0010; d_wdata = 32'h0000_00AB;
    step();
    idle();
    repeat (5) step();

    // Back-to-back loads
    for (int n = 0; n < 10; n++) begin
      d_req = 1; d_we = 0; d_size = SIZE_WORD; d_rdun = 0; d_addr = $urandom;
      step();
    end
    idle();
    repeat (4) step();

    // Reset while a store is in flight
    d_req = 1; d_we = 1; d_size = SIZE_WORD; d_addr = 32'h0100_0020; d_wdata = 32'hCAFE_F00D;
    step();
    idle();
    #1;
    check_val("L1 store mem_we", bus1.mem_we, 1);
    check_val("L3 store mem_we", bus3.mem_we, 1);
    rst_n = 0;
    #1;
    check_val("L1 mid-reset mem_we",   bus1.mem_we,   0);
    check_val("L3 mid-reset mem_we",   bus3.mem_we,   0);
    check_val("L1 mid-reset d_rvalid", bus1.d_rvalid, 0);
    check_val("L3 mid-reset d_rvalid", bus3.d_rvalid, 0);
    do_reset();
    repeat (3) step();
    i_req = 1; i_addr = 32'h0100_0004;
    step();
    idle();
    repeat (4) step();

    // 10 fetch grants then 5 data grants
    do_reset();
    for (int n = 0; n < 10; n++) begin
      i_req = 1; i_addr = $urandom;
      step();
    end
    i_req = 0;
    for (int n = 0; n < 5; n++) begin
      d_req = 1; d_we = 0; d_addr = $urandom;
      step();
    end
    idle();
    repeat (4) step();
`ifdef ARB_PERF_CNT_EN
    check_val("L1 perf_i_grants", p1_ig, 10);
    check_val("L1 perf_d_grants", p1_dg, 5);
    check_val("L1 perf_i_stall",  p1_st, 0);
    check_val("L3 perf_i_grants", p3_ig, m_ig[1]);
    check_val("L3 perf_d_grants", p3_dg, m_dg[1]);
    check_val("L3 perf_i_stall",  p3_st, m_st[1]);
`endif

    // Random contention
    do_reset();
    for (int n = 0; n < 800; n++) begin
      i_req   = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = $urandom_range(0, 1);
      d_size  = 2'($urandom_range(0, 2));
      d_rdun  = $urandom_range(0, 1);
      step();
    end
    idle();
    repeat (4) step();
`ifdef ARB_PERF_CNT_EN
    check_val("L1 rand perf_i_grants", p1_ig, m_ig[0]);
    check_val("L1 rand perf_d_grants", p1_dg, m_dg[0]);
    check_val("L1 rand perf_i_stall",  p1_st, m_st[0]);
    check_val("L3 rand perf_i_grants", p3_ig, m_ig[1]);
    check_val("L3 rand perf_d_grants", p3_dg, m_dg[1]);
    check_val("L3 rand perf_i_stall",  p3_st, m_st[1]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
